// File: rtl/arena_frame_rx.sv
// Arena snapshot frame receiver: sync byte, 13 payload bytes, XOR checksum.
// Good frames update arena_map; rejected or timed-out frames bump err_count.
module arena_frame_rx #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [99:0]  arena_map,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [7:0]   err_count,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_t;

  state_t         state, state_d;
  logic [3:0]     idx, idx_d;
  logic [7:0]     xsum, xsum_d;
  logic [103:0]   shadow, shadow_d;
  logic [TW-1:0]  tcnt, tcnt_d;
  logic           valid_d, err_d;
  logic           tmo;

  // Idle limit hit this cycle; a byte arriving now wins over the timeout.
  assign tmo  = (state != HUNT) && !rx_valid && (tcnt == TLAST);
  assign busy = (state != HUNT);

  // Next-state, frame assembly and result decode.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    xsum_d   = xsum;
    shadow_d = shadow;
    tcnt_d   = tcnt;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      HUNT: begin
        tcnt_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = 4'd0;
          xsum_d  = 8'h00;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          tcnt_d = '0;
          shadow_d[{idx, 3'b000} +: 8] = rx_data;
          xsum_d = xsum ^ rx_data;
          if (idx == 4'd12) state_d = CHECK;
          else idx_d = idx + 4'd1;
        end else if (tmo) begin
          tcnt_d  = '0;
          state_d = HUNT;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          tcnt_d  = '0;
          state_d = HUNT;
          if (rx_data == xsum && shadow[103:100] == 4'h0)
            valid_d = 1'b1;
          else
            err_d = 1'b1;
        end else if (tmo) begin
          tcnt_d  = '0;
          state_d = HUNT;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State, shadow, snapshot and error counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      idx         <= 4'd0;
      xsum        <= 8'h00;
      shadow      <= '0;
      tcnt        <= '0;
      arena_map   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      xsum        <= xsum_d;
      shadow      <= shadow_d;
      tcnt        <= tcnt_d;
      frame_valid <= valid_d;
      frame_err   <= err_d;
      if (valid_d)
        arena_map <= shadow[99:0];
      if (err_d && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_arena_frame_rx.sv
// Directed bench for arena_frame_rx with a 16-cycle timeout.
// Each step drives bytes on negedge and checks registered outputs.
module tb_arena_frame_rx;

  typedef logic [7:0] pl_t [13];

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [99:0] arena_map;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int n_vec;
  int n_err;

  arena_frame_rx #(
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .arena_map(arena_map),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .err_count(err_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [99:0] obs,
                       input logic [99:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input pl_t p, input logic [7:0] c);
    send(8'hA5);
    for (int k = 0; k < 13; k++) send(p[k]);
    send(c);
  endtask

  pl_t p;
  logic [99:0] exp1, exp2, exp3, exp4;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_map", arena_map, 100'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_errc", err_count, 8'd0);
    rst = 1'b0;
    idle(1);

    // Good frame: bit0 and bit99 set.
    p = '{default: 8'h00};
    p[0] = 8'h01;
    p[12] = 8'h08;
    exp1 = '0;
    exp1[0] = 1'b1;
    exp1[99] = 1'b1;
    frame(p, 8'h09);
    check("good_fv", frame_valid, 1'b1);
    check("good_fe", frame_err, 1'b0);
    check("good_map", arena_map, exp1);
    check("good_errc", err_count, 8'd0);
    check("good_busy", busy, 1'b0);
    idle(1);
    check("good_fv_pulse", frame_valid, 1'b0);

    // Bad checksum.
    frame(p, 8'h00);
    check("badchk_fe", frame_err, 1'b1);
    check("badchk_fv", frame_valid, 1'b0);
    check("badchk_map", arena_map, exp1);
    check("badchk_errc", err_count, 8'd1);
    idle(1);
    check("badchk_fe_pulse", frame_err, 1'b0);

    // Pad bits set in P12 with correct XOR.
    p[12] = 8'h10;
    frame(p, 8'h11);
    check("pad_fe", frame_err, 1'b1);
    check("pad_fv", frame_valid, 1'b0);
    check("pad_map", arena_map, exp1);
    check("pad_errc", err_count, 8'd2);
    idle(1);

    // Timeout after sync plus five payload bytes.
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    check("tmo_busy_mid", busy, 1'b1);
    idle(15);
    check("tmo_busy_15", busy, 1'b1);
    check("tmo_fe_15", frame_err, 1'b0);
    idle(1);
    check("tmo_fe", frame_err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_errc", err_count, 8'd3);
    check("tmo_map", arena_map, exp1);
    idle(1);
    check("tmo_fe_pulse", frame_err, 1'b0);

    // Noise bytes, then a good frame.
    send(8'h00);
    send(8'hFF);
    p = '{default: 8'h00};
    p[0] = 8'hFF;
    p[5] = 8'h3C;
    p[12] = 8'h05;
    exp2 = '0;
    exp2[7:0] = 8'hFF;
    exp2[47:40] = 8'h3C;
    exp2[99:96] = 4'h5;
    frame(p, 8'hC6);
    check("noise_fv", frame_valid, 1'b1);
    check("noise_map", arena_map, exp2);

    // Back-to-back frame with embedded sync values as data.
    p = '{default: 8'h00};
    p[0] = 8'hA5;
    p[3] = 8'hA5;
    p[7] = 8'h5A;
    exp3 = '0;
    exp3[7:0] = 8'hA5;
    exp3[31:24] = 8'hA5;
    exp3[63:56] = 8'h5A;
    frame(p, 8'h5A);
    check("b2b_fv", frame_valid, 1'b1);
    check("b2b_map", arena_map, exp3);
    check("b2b_errc", err_count, 8'd3);
    idle(2);

    // Byte arriving on the cycle the timeout would fire is kept.
    p = '{default: 8'h00};
    p[1] = 8'h80;
    p[12] = 8'h01;
    exp4 = '0;
    exp4[15] = 1'b1;
    exp4[96] = 1'b1;
    send(8'hA5);
    idle(15);
    for (int k = 0; k < 13; k++) send(p[k]);
    send(8'h81);
    check("edge_fv", frame_valid, 1'b1);
    check("edge_map", arena_map, exp4);
    check("edge_errc", err_count, 8'd3);
    idle(1);

    // Reset mid-frame, with rx_valid high on the reset edge.
    send(8'hA5);
    for (int k = 0; k < 7; k++) send(8'h5A);
    rst = 1'b1;
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_map", arena_map, 100'd0);
    check("mrst_fe", frame_err, 1'b0);
    check("mrst_errc", err_count, 8'd0);
    idle(1);
    check("mrst_fe_after", frame_err, 1'b0);
    check("mrst_busy_after", busy, 1'b0);

    // Error counter saturation.
    p = '{default: 8'h00};
    frame(p, 8'h01);
    check("sat_errc_1", err_count, 8'd1);
    repeat (255) frame(p, 8'h01);
    check("sat_errc_255", err_count, 8'd255);
    frame(p, 8'h01);
    check("sat_errc_hold", err_count, 8'd255);
    check("sat_fe", frame_err, 1'b1);
    check("sat_map", arena_map, 100'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arena_frame_rx.md
ARENA_FRAME_RX -- requirements
Module: arena_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum idle clk cycles allowed between bytes inside a frame.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8: received UART byte.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port arena_map, output, 100: last good arena snapshot; bit i = cell i.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when arena_map updates.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on any rejected frame.
REQ-010 SHALL have port err_count, output, 8: count of rejected frames, saturating.
REQ-011 SHALL have port busy, output, 1: high while a frame is being assembled.

Function
REQ-012 Frame format SHALL be: SYNC_BYTE, 13 payload bytes P0..P12, 1 checksum byte = P0 XOR P1 XOR ... XOR P12.
REQ-013 Payload byte Pk SHALL carry arena bits [8k+7:8k], LSB first; P12[7:4] SHALL be zero.
REQ-014 State machine SHALL have states HUNT, PAYLOAD, CHECK; only cycles with rx_valid=1 advance it.
REQ-015 HUNT: byte == SYNC_BYTE -> PAYLOAD, byte index 0, running XOR 0; any other byte is discarded silently, no error.
REQ-016 PAYLOAD: each byte SHALL be stored into a shadow register (not arena_map) at index k and XORed into the running checksum; after P12 -> CHECK.
REQ-017 A SYNC_BYTE value received in PAYLOAD or CHECK SHALL be treated as data, not as a restart.
REQ-018 CHECK: byte equal to running XOR and P12[7:4]==0 -> copy shadow[99:0] to arena_map, pulse frame_valid; otherwise pulse frame_err, arena_map unchanged; both cases -> HUNT.
REQ-019 Latency: frame_valid/frame_err SHALL be high exactly the cycle after the clk edge sampling the checksum byte; arena_map SHALL change on that same edge.
REQ-020 Timeout counter SHALL clear on every accepted byte and increment each cycle in PAYLOAD or CHECK without rx_valid; on reaching TIMEOUT_CYCLES -> HUNT, pulse frame_err.
REQ-021 No timeout SHALL apply in HUNT.
REQ-022 rx_valid on the same cycle the timeout is reached SHALL be accepted as a byte; timeout is not taken.
REQ-023 err_count SHALL increment by 1 per frame_err pulse and hold at 255.
REQ-024 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss, including SYNC_BYTE of the next frame the cycle after a checksum byte.
REQ-025 busy SHALL be 1 in PAYLOAD and CHECK, 0 in HUNT.
REQ-026 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 at a clk edge SHALL force HUNT, arena_map=0, shadow=0, frame_valid=0, frame_err=0, err_count=0, busy=0, timeout counter=0.
REQ-028 rst mid-frame SHALL discard the partial frame without a frame_err pulse; rst dominates rx_valid on the same edge.

Verification
REQ-029 Good frame: A5, P0=01, P1..P11=00, P12=08, chk=09 -> frame_valid one cycle, arena_map bit0=1 and bit99=1, all other bits 0, err_count=0.
REQ-030 Bad checksum: same frame with chk=00 -> frame_err one cycle, arena_map unchanged, err_count=1.
REQ-031 Pad violation: P12=10 with correct XOR checksum -> frame_err, arena_map unchanged.
REQ-032 Timeout: A5 plus 5 payload bytes, then no rx_valid for TIMEOUT_CYCLES (set to 16) -> frame_err after 16 idle cycles, busy=0; next full good frame accepted.
REQ-033 Noise and embedded sync: bytes 00, FF before A5 -> ignored; payload containing A5 values with correct checksum -> accepted as data.
REQ-034 Reset mid-frame after 7 payload bytes -> busy=0, arena_map=0, no frame_err; 256 bad frames -> err_count stays 255.
